// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_pkg : shared types and constants for the pipelined MIPS core           |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Operand source chosen by the bypass network
  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_W   = 2'd1,
    FWD_M   = 2'd2,
    FWD_E   = 2'd3
  } fwd_sel_t;

endpackage

`default_nettype wire

// File: rtl/opnd_bypass_mux.sv
// +----------------------------------------------------------------------------+
// | opnd_bypass_mux : resolves one source operand from E/M/W bypass or the GRF |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module opnd_bypass_mux
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] addr,
  input  logic          used,
  input  logic          e_wen,
  input  logic [AW-1:0] e_a3,
  input  logic          e_rdy,
  input  logic [DW-1:0] e_data,
  input  logic          m_wen,
  input  logic [AW-1:0] m_a3,
  input  logic          m_rdy,
  input  logic [DW-1:0] m_data,
  input  logic          w_wen,
  input  logic [AW-1:0] w_a3,
  input  logic [DW-1:0] w_data,
  input  logic [DW-1:0] rd,
  output logic [DW-1:0] value,
  output fwd_sel_t      fwd_sel,
  output logic          stall
);

  logic addr_nz;
  logic e_hit;
  logic m_hit;
  logic w_hit;

  // Register zero is never forwarded, so a producer targeting $0 can't stall us
  assign addr_nz = (addr != AW'(REG_ZERO));
  assign e_hit   = addr_nz & e_wen & (e_a3 == addr);
  assign m_hit   = addr_nz & m_wen & (m_a3 == addr);
  assign w_hit   = addr_nz & w_wen & (w_a3 == addr);

  always_comb begin
    value   = rd;
    fwd_sel = FWD_GRF;
    stall   = 1'b0;
    if (!addr_nz) begin
      value = '0;
    end else if (e_hit) begin
      value   = e_data;
      fwd_sel = FWD_E;
      stall   = used & ~e_rdy;
    end else if (m_hit) begin
      value   = m_data;
      fwd_sel = FWD_M;
      stall   = used & ~m_rdy;
    end else if (w_hit) begin
      // GRF write lands only at the edge, so RD still shows the old value
      value   = w_data;
      fwd_sel = FWD_W;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// +----------------------------------------------------------------------------+
// | operand_fetch : ID-stage GRF read, bypass, load-use stall, EX output stage |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic             in_rs_used,
  input  logic             in_rt_used,
  input  logic [DW-1:0]    in_pc,
  output logic [AW-1:0]    a1,
  output logic [AW-1:0]    a2,
  input  logic [DW-1:0]    RD1,
  input  logic [DW-1:0]    RD2,
  input  logic             e_wen,
  input  logic             m_wen,
  input  logic             w_wen,
  input  logic [AW-1:0]    e_a3,
  input  logic [AW-1:0]    m_a3,
  input  logic [AW-1:0]    w_a3,
  input  logic             e_rdy,
  input  logic             m_rdy,
  input  logic [DW-1:0]    e_data,
  input  logic [DW-1:0]    m_data,
  input  logic [DW-1:0]    w_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_rs_val,
  output logic [DW-1:0]    out_rt_val,
  output logic [DW-1:0]    out_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DW-1:0]    rs_val;
  logic [DW-1:0]    rt_val;
  fwd_sel_t         rs_sel;
  fwd_sel_t         rt_sel;
  logic             rs_stall;
  logic             rt_stall;
  logic             hazard;
  logic             accept;
  logic [1:0]       unused_fwd_sel;

  logic             out_valid_d, out_valid_q;
  logic [DW-1:0]    rs_val_d, rs_val_q;
  logic [DW-1:0]    rt_val_d, rt_val_q;
  logic [DW-1:0]    pc_d, pc_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign a1 = in_rs;
  assign a2 = in_rt;

  opnd_bypass_mux #(.DW(DW), .AW(AW)) u_rs_mux (
    .addr    (in_rs),
    .used    (in_rs_used),
    .e_wen   (e_wen),
    .e_a3    (e_a3),
    .e_rdy   (e_rdy),
    .e_data  (e_data),
    .m_wen   (m_wen),
    .m_a3    (m_a3),
    .m_rdy   (m_rdy),
    .m_data  (m_data),
    .w_wen   (w_wen),
    .w_a3    (w_a3),
    .w_data  (w_data),
    .rd      (RD1),
    .value   (rs_val),
    .fwd_sel (rs_sel),
    .stall   (rs_stall)
  );

  opnd_bypass_mux #(.DW(DW), .AW(AW)) u_rt_mux (
    .addr    (in_rt),
    .used    (in_rt_used),
    .e_wen   (e_wen),
    .e_a3    (e_a3),
    .e_rdy   (e_rdy),
    .e_data  (e_data),
    .m_wen   (m_wen),
    .m_a3    (m_a3),
    .m_rdy   (m_rdy),
    .m_data  (m_data),
    .w_wen   (w_wen),
    .w_a3    (w_a3),
    .w_data  (w_data),
    .rd      (RD2),
    .value   (rt_val),
    .fwd_sel (rt_sel),
    .stall   (rt_stall)
  );

  // Source selects are kept for debug visibility only
  assign unused_fwd_sel = rs_sel ^ rt_sel;

  assign hazard   = rs_stall | rt_stall;
  assign in_ready = ~hazard & (~out_valid_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      rs_val_d    = rs_val;
      rt_val_d    = rt_val;
      pc_d        = in_pc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (in_valid && hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      pc_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rs_val = rs_val_q;
  assign out_rt_val = rt_val_q;
  assign out_pc     = pc_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_operand_fetch : scoreboard bench for operand_fetch                      |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_operand_fetch;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, in_rs_used, in_rt_used;
  logic [AW-1:0]    in_rs, in_rt, a1, a2, e_a3, m_a3, w_a3;
  logic [DW-1:0]    in_pc, RD1, RD2, e_data, m_data, w_data;
  logic             e_wen, m_wen, w_wen, e_rdy, m_rdy;
  logic             out_valid, out_ready;
  logic [DW-1:0]    out_rs_val, out_rt_val, out_pc;
  logic [CNT_W-1:0] stall_cnt;

  logic [DW-1:0]    grf [32];

  typedef struct packed {
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    logic [DW-1:0] pc;
  } entry_t;

  entry_t           sb[$];
  entry_t           held;
  logic             mv;
  logic [CNT_W-1:0] exp_cnt;
  logic [CNT_W-1:0] base_cnt;
  int               n_vec = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  assign RD1 = grf[a1];
  assign RD2 = grf[a2];

  operand_fetch #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rs_used (in_rs_used),
    .in_rt_used (in_rt_used),
    .in_pc      (in_pc),
    .a1         (a1),
    .a2         (a2),
    .RD1        (RD1),
    .RD2        (RD2),
    .e_wen      (e_wen),
    .m_wen      (m_wen),
    .w_wen      (w_wen),
    .e_a3       (e_a3),
    .m_a3       (m_a3),
    .w_a3       (w_a3),
    .e_rdy      (e_rdy),
    .m_rdy      (m_rdy),
    .e_data     (e_data),
    .m_data     (m_data),
    .w_data     (w_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs_val (out_rs_val),
    .out_rt_val (out_rt_val),
    .out_pc     (out_pc),
    .stall_cnt  (stall_cnt)
  );

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference resolution: {stall, value}, using the GRF array directly
  function automatic logic [DW:0] resolve(input logic [AW-1:0] a, input logic used);
    if (a == 0)                      return {1'b0, {DW{1'b0}}};
    else if (e_wen && e_a3 == a)     return {used & ~e_rdy, e_data};
    else if (m_wen && m_a3 == a)     return {used & ~m_rdy, m_data};
    else if (w_wen && w_a3 == a)     return {1'b0, w_data};
    else                             return {1'b0, grf[a]};
  endfunction

  task automatic tick();
    logic [DW:0] rs_r, rt_r;
    logic        haz, rdy_exp, acc, cons;
    #2;
    rs_r    = resolve(in_rs, in_rs_used);
    rt_r    = resolve(in_rt, in_rt_used);
    haz     = rs_r[DW] | rt_r[DW];
    rdy_exp = !haz && (!mv || out_ready) && !flush;
    chk("a1", {91'd0, a1}, {91'd0, in_rs});
    chk("a2", {91'd0, a2}, {91'd0, in_rt});
    if (!reset) chk("in_ready", {95'd0, in_ready}, {95'd0, rdy_exp});
    acc = !reset && in_valid && rdy_exp;
    if (acc) sb.push_back({rs_r[DW-1:0], rt_r[DW-1:0], in_pc});
    if (reset) exp_cnt = '0;
    else if (in_valid && haz && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    cons = mv && out_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      mv   = 1'b0;
      held = '0;
      sb.delete();
    end else if (flush) begin
      mv = 1'b0;
    end else if (acc) begin
      mv   = 1'b1;
      held = sb.pop_front();
    end else if (cons) begin
      mv = 1'b0;
    end
    chk("out_valid", {95'd0, out_valid}, {95'd0, mv});
    chk("out_entry", {out_rs_val, out_rt_val, out_pc}, held);
    chk("stall_cnt", {64'd0, stall_cnt}, {64'd0, exp_cnt});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) grf[i] = 32'h100 + i;
    grf[3] = 32'h11;
    mv = 1'b0; held = '0; exp_cnt = '0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs = '0; in_rt = '0; in_rs_used = 1'b0; in_rt_used = 1'b0; in_pc = '0;
    e_wen = 1'b0; m_wen = 1'b0; w_wen = 1'b0; e_rdy = 1'b0; m_rdy = 1'b0;
    e_a3 = '0; m_a3 = '0; w_a3 = '0; e_data = '0; m_data = '0; w_data = '0;
    tick(); tick();
    reset = 1'b0;

    // Plain GRF read
    in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd4; in_rs_used = 1'b1; in_rt_used = 1'b1;
    in_pc = 32'h1000; out_ready = 1'b1;
    tick();
    chk("nohaz_rs", {64'd0, out_rs_val}, 96'h11);

    // Bypass priority E > M > W
    in_rs = 5'd5; in_pc = 32'h1004;
    e_wen = 1'b1; e_a3 = 5'd5; e_data = 32'hA; e_rdy = 1'b1;
    m_wen = 1'b1; m_a3 = 5'd5; m_data = 32'hB; m_rdy = 1'b1;
    w_wen = 1'b1; w_a3 = 5'd5; w_data = 32'hC;
    tick(); chk("prio_e", {64'd0, out_rs_val}, 96'hA);
    e_wen = 1'b0;
    tick(); chk("prio_m", {64'd0, out_rs_val}, 96'hB);
    m_wen = 1'b0;
    tick(); chk("prio_w", {64'd0, out_rs_val}, 96'hC);
    w_wen = 1'b0;

    // Load-use on rt
    in_rs = 5'd0; in_rt = 5'd8; in_pc = 32'h1008;
    m_wen = 1'b1; m_a3 = 5'd8; m_rdy = 1'b0;
    base_cnt = exp_cnt;
    tick(); tick();
    chk("ld_use_cnt", {64'd0, stall_cnt}, {64'd0, base_cnt + 32'd2});
    m_rdy = 1'b1; m_data = 32'h77;
    tick(); chk("ld_use_rt", {64'd0, out_rt_val}, 96'h77);
    m_wen = 1'b0;

    // $0 never stalls and reads as zero
    in_rs = 5'd0; in_rt = 5'd1; in_rt_used = 1'b0; in_pc = 32'h100C;
    e_wen = 1'b1; e_a3 = 5'd0; e_rdy = 1'b0; e_data = 32'hDEAD;
    tick(); chk("zero_rs", {64'd0, out_rs_val}, 96'h0);
    e_wen = 1'b0;

    // Backpressure then flush
    out_ready = 1'b0; in_rs = 5'd2; in_rt = 5'd6; in_rt_used = 1'b1; in_pc = 32'h2000;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    chk("flush_valid", {95'd0, out_valid}, 96'h0);
    flush = 1'b0; out_ready = 1'b1;
    tick();

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 49) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      in_valid   = $urandom_range(0, 3) != 0;
      out_ready  = $urandom_range(0, 3) != 0;
      in_rs      = AW'($urandom_range(0, 7));
      in_rt      = AW'($urandom_range(0, 7));
      in_rs_used = $urandom_range(0, 1);
      in_rt_used = $urandom_range(0, 1);
      in_pc      = $urandom;
      e_wen      = $urandom_range(0, 1); e_a3 = AW'($urandom_range(0, 7));
      m_wen      = $urandom_range(0, 1); m_a3 = AW'($urandom_range(0, 7));
      w_wen      = $urandom_range(0, 1); w_a3 = AW'($urandom_range(0, 7));
      e_rdy      = $urandom_range(0, 2) != 0;
      m_rdy      = $urandom_range(0, 2) != 0;
      e_data     = $urandom; m_data = $urandom; w_data = $urandom;
      tick();
    end

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
